ysyx_25030081_lsu: RTL and testbench

Load/store unit downstream of the control unit and ALU. It consumes a decoded memory request: address from the ALU, store data from rs2, and the control unit's mem_wen/mem_ren/mem_op fields. It performs one transaction on the data-memory bus using a valid/ready request/response handshake. For stores it aligns data and builds the write strobe; for loads it extracts the addressed byte/half/word and sign- or zero-extends it before handing the result to writeback.

---
 rtl/ysyx_25030081_lsu_pkg.sv | 39 +++
 rtl/ysyx_25030081_lsu_align.sv | 43 ++++
 rtl/ysyx_25030081_lsu.sv | 147 ++++++++++++++
 tb/tb_ysyx_25030081_lsu.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030081_lsu_pkg.sv
// Shared LSU definitions: FSM states, mem_op encodings and the bus request payload.
package ysyx_25030081_lsu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned STRB_W = XLEN / 8;

   // Must match the encodings the control unit drives on mem_op.
   localparam logic [2:0] MEM_OP_B  = 3'b000;
   localparam logic [2:0] MEM_OP_H  = 3'b001;
   localparam logic [2:0] MEM_OP_W  = 3'b010;
   localparam logic [2:0] MEM_OP_BU = 3'b100;
   localparam logic [2:0] MEM_OP_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic              wen;
      logic [XLEN-1:0]   wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_req_t;

   // Word accesses need addr[1:0]==0, half accesses need addr[0]==0.
   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      if (op[1])
         mis = (lo != 2'b00);
      else if (op[0])
         mis = lo[0];
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_25030081_lsu_align.sv
// Store lane replication / strobe generation and load extract / extend.
module ysyx_25030081_lsu_align
   import ysyx_25030081_lsu_pkg::*;
(
   input  logic [1:0]        addr_lo,
   input  logic [2:0]        op,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   lane_wdata_c,
   output logic [STRB_W-1:0] wstrb_c,
   output logic [XLEN-1:0]   ext_rdata_c
);

   logic            is_word;
   logic            is_half;
   logic            is_unsigned;
   logic [XLEN-1:0] shifted;

   assign is_word     = op[1];
   assign is_half     = (op[1:0] == MEM_OP_H[1:0]);
   assign is_unsigned = op[2];
   assign shifted     = rdata >> {addr_lo, 3'b000};

   always_comb begin
      lane_wdata_c = wdata;
      wstrb_c      = 4'b1111;
      ext_rdata_c  = shifted;
      if (!is_word) begin
         if (is_half) begin
            lane_wdata_c = {2{wdata[15:0]}};
            wstrb_c      = 4'b0011 << addr_lo;
            ext_rdata_c  = is_unsigned ? {16'h0000, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
         end else begin
            lane_wdata_c = {4{wdata[7:0]}};
            wstrb_c      = 4'b0001 << addr_lo;
            ext_rdata_c  = is_unsigned ? {24'h000000, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
         end
      end
   end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: one valid/ready bus transaction per accepted request.
module ysyx_25030081_lsu
   import ysyx_25030081_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1023,
   parameter int unsigned TCNT_W      = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic        in_wen,
   input  logic        in_ren,
   input  logic [2:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready,
   input  logic [31:0] mem_resp_rdata,
   input  logic        mem_resp_err
);

   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

   lsu_state_e        state;
   mem_req_t          req_q;
   logic              wen_q;
   logic [1:0]        addr_lo_q;
   logic [2:0]        op_q;
   logic [TCNT_W-1:0] tcnt;

   logic [1:0]        sel_lo;
   logic [2:0]        sel_op;
   logic [31:0]       lane_wdata_c;
   logic [3:0]        wstrb_c;
   logic [31:0]       ext_rdata_c;

   // Stores are aligned from the live inputs at accept; loads extract from the latched request.
   assign sel_lo = (state == ST_IDLE) ? in_addr[1:0] : addr_lo_q;
   assign sel_op = (state == ST_IDLE) ? in_op        : op_q;

   ysyx_25030081_lsu_align u_align (
      .addr_lo      (sel_lo),
      .op           (sel_op),
      .wdata        (in_wdata),
      .rdata        (mem_resp_rdata),
      .lane_wdata_c (lane_wdata_c),
      .wstrb_c      (wstrb_c),
      .ext_rdata_c  (ext_rdata_c)
   );

   assign mem_req_addr  = req_q.addr;
   assign mem_req_wen   = req_q.wen;
   assign mem_req_wdata = req_q.wdata;
   assign mem_req_wstrb = req_q.wstrb;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         out_rdata      <= '0;
         out_err        <= 1'b0;
         mem_req_valid  <= 1'b0;
         mem_resp_ready <= 1'b0;
         req_q          <= '0;
         wen_q          <= 1'b0;
         addr_lo_q      <= 2'b00;
         op_q           <= 3'b000;
         tcnt           <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready  <= 1'b0;
                  wen_q     <= in_wen;
                  addr_lo_q <= in_addr[1:0];
                  op_q      <= in_op;
                  tcnt      <= '0;
                  if (!in_wen && !in_ren) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     out_rdata <= '0;
                     out_err   <= 1'b0;
                  end else if (is_misaligned(in_op, in_addr[1:0])) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     out_rdata <= '0;
                     out_err   <= 1'b1;
                  end else begin
                     state         <= ST_REQ;
                     mem_req_valid <= 1'b1;
                     req_q.addr    <= {in_addr[31:2], 2'b00};
                     req_q.wen     <= in_wen;
                     req_q.wdata   <= in_wen ? lane_wdata_c : 32'h0;
                     req_q.wstrb   <= in_wen ? wstrb_c : 4'b0000;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  state          <= ST_RESP;
                  mem_req_valid  <= 1'b0;
                  mem_resp_ready <= 1'b1;
               end
            end
            ST_RESP: begin
               // A response in the timeout cycle takes precedence over the abort.
               if (mem_resp_valid) begin
                  state          <= ST_DONE;
                  mem_resp_ready <= 1'b0;
                  out_valid      <= 1'b1;
                  out_rdata      <= wen_q ? 32'h0 : ext_rdata_c;
                  out_err        <= mem_resp_err;
               end else if ((TIMEOUT_CYC != 0) && (tcnt == TCNT_LAST)) begin
                  state          <= ST_DONE;
                  mem_resp_ready <= 1'b0;
                  out_valid      <= 1'b1;
                  out_rdata      <= '0;
                  out_err        <= 1'b1;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Directed bench for the LSU: vector table plus stall, timeout and reset sequences.
module tb_ysyx_25030081_lsu;
   import ysyx_25030081_lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        in_wen;
   logic        in_ren;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rdata;
   logic        out_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_rdata;
   logic        mem_resp_err;

   logic        req_rdy_en;
   logic        resp_en;
   logic [31:0] bus_rdata;
   logic        bus_err;

   int checks;
   int errors;

   ysyx_25030081_lsu #(.TIMEOUT_CYC(4), .TCNT_W(10)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_addr        (in_addr),
      .in_wdata       (in_wdata),
      .in_wen         (in_wen),
      .in_ren         (in_ren),
      .in_op          (in_op),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rdata      (out_rdata),
      .out_err        (out_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wen    (mem_req_wen),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wstrb  (mem_req_wstrb),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_rdata (mem_resp_rdata),
      .mem_resp_err   (mem_resp_err)
   );

   // Zero-wait bus: responds in the same cycle resp_ready is seen, when enabled.
   assign mem_req_ready  = req_rdy_en;
   assign mem_resp_valid = mem_resp_ready & resp_en;
   assign mem_resp_rdata = bus_rdata;
   assign mem_resp_err   = bus_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic        wen;
      logic        ren;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brdata;
      logic        berr;
      logic        xreq;
      logic [31:0] xaddr;
      logic [31:0] xwdata;
      logic [3:0]  xstrb;
      logic [31:0] xrdata;
      logic        xerr;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is in IDLE, #1 after a posedge; returns in IDLE, #1 after a posedge.
   task automatic run_vec(input vec_t v, input int idx);
      in_valid  = 1'b1;
      in_addr   = v.addr;
      in_wdata  = v.wdata;
      in_wen    = v.wen;
      in_ren    = v.ren;
      in_op     = v.op;
      bus_rdata = v.brdata;
      bus_err   = v.berr;
      chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (v.xreq) begin
         chk($sformatf("v%0d_req_valid", idx), 32'(mem_req_valid), 32'd1);
         chk($sformatf("v%0d_req_addr", idx), mem_req_addr, v.xaddr);
         chk($sformatf("v%0d_req_wen", idx), 32'(mem_req_wen), 32'(v.wen));
         chk($sformatf("v%0d_req_wdata", idx), mem_req_wdata, v.xwdata);
         chk($sformatf("v%0d_req_wstrb", idx), 32'(mem_req_wstrb), 32'(v.xstrb));
         @(posedge clk); #1;
         chk($sformatf("v%0d_resp_ready", idx), 32'(mem_resp_ready), 32'd1);
         chk($sformatf("v%0d_out_valid_early", idx), 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end else begin
         chk($sformatf("v%0d_no_req", idx), 32'(mem_req_valid), 32'd0);
      end
      chk($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_out_rdata", idx), out_rdata, v.xrdata);
      chk($sformatf("v%0d_out_err", idx), 32'(out_err), 32'(v.xerr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid_drop", idx), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_in_ready_back", idx), 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] st_addr;
      logic [31:0] st_rdata;

      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_addr    = '0;
      in_wdata   = '0;
      in_wen     = 1'b0;
      in_ren     = 1'b0;
      in_op      = 3'b000;
      out_ready  = 1'b1;
      req_rdy_en = 1'b1;
      resp_en    = 1'b1;
      bus_rdata  = '0;
      bus_err    = 1'b0;

      //             wen   ren   op         addr          wdata         brdata        berr  xreq  xaddr         xwdata        xstrb    xrdata        xerr
      vecs[0]  = '{1'b1, 1'b0, MEM_OP_W,  32'h80000004, 32'hDEADBEEF, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000004, 32'hDEADBEEF, 4'b1111, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, MEM_OP_B,  32'h80000003, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 32'hFFFFFF80, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, MEM_OP_BU, 32'h80000003, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 32'h00000080, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, MEM_OP_H,  32'h80000002, 32'h00001234, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h12341234, 4'b1100, 32'h00000000, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, MEM_OP_H,  32'h80000001, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, MEM_OP_H,  32'h80000002, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 32'hFFFF80AA, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, MEM_OP_HU, 32'h80000000, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 32'h0000BBCC, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, MEM_OP_W,  32'h80000008, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000008, 32'h00000000, 4'b0000, 32'h80AABBCC, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, MEM_OP_B,  32'h80000001, 32'h000000A5, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'hA5A5A5A5, 4'b0010, 32'h00000000, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, MEM_OP_W,  32'h80000002, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 1'b1};
      vecs[10] = '{1'b1, 1'b0, MEM_OP_W,  32'h80000001, 32'h11111111, 32'h80AABBCC, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 1'b1};
      vecs[11] = '{1'b0, 1'b0, MEM_OP_W,  32'h80000003, 32'h22222222, 32'h80AABBCC, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 1'b0};
      vecs[12] = '{1'b0, 1'b1, MEM_OP_B,  32'h80000001, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 32'hFFFFFFBB, 1'b0};
      vecs[13] = '{1'b0, 1'b1, MEM_OP_BU, 32'h80000000, 32'h00000000, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 32'h000000CC, 1'b0};
      vecs[14] = '{1'b1, 1'b1, MEM_OP_W,  32'h8000000C, 32'h11223344, 32'h80AABBCC, 1'b0, 1'b1, 32'h8000000C, 32'h11223344, 4'b1111, 32'h00000000, 1'b0};
      vecs[15] = '{1'b0, 1'b1, MEM_OP_W,  32'h80000024, 32'h00000000, 32'h80AABBCC, 1'b1, 1'b1, 32'h80000024, 32'h00000000, 4'b0000, 32'h80AABBCC, 1'b1};
      vecs[16] = '{1'b1, 1'b0, MEM_OP_H,  32'h80000000, 32'hABCD5678, 32'h80AABBCC, 1'b0, 1'b1, 32'h80000000, 32'h56785678, 4'b0011, 32'h00000000, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_rdata", out_rdata, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_resp_ready", 32'(mem_resp_ready), 32'd0);
      chk("rst_req_wstrb", 32'(mem_req_wstrb), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Back-pressure on both bus request and writeback
      st_addr    = 32'h80000010;
      st_rdata   = 32'h12345678;
      req_rdy_en = 1'b0;
      resp_en    = 1'b0;
      out_ready  = 1'b0;
      bus_err    = 1'b0;
      in_valid   = 1'b1;
      in_addr    = st_addr;
      in_wen     = 1'b0;
      in_ren     = 1'b1;
      in_op      = MEM_OP_W;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_addr  = 32'h0;
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("stall_req_valid_c%0d", c), 32'(mem_req_valid), 32'd1);
         chk($sformatf("stall_req_addr_c%0d", c), mem_req_addr, st_addr);
         chk($sformatf("stall_req_wen_c%0d", c), 32'(mem_req_wen), 32'd0);
         chk($sformatf("stall_req_wstrb_c%0d", c), 32'(mem_req_wstrb), 32'd0);
         chk($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
         if (c < 5) begin
            @(posedge clk); #1;
         end
      end
      req_rdy_en = 1'b1;
      @(posedge clk); #1;
      req_rdy_en = 1'b0;
      bus_rdata  = st_rdata;
      chk("stall_resp_ready", 32'(mem_resp_ready), 32'd1);
      chk("stall_req_dropped", 32'(mem_req_valid), 32'd0);
      @(posedge clk); #1;
      chk("stall_still_waiting", 32'(out_valid), 32'd0);
      resp_en = 1'b1;
      @(posedge clk); #1;
      resp_en   = 1'b0;
      bus_rdata = 32'hFFFFFFFF;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("hold_out_valid_c%0d", c), 32'(out_valid), 32'd1);
         chk($sformatf("hold_out_rdata_c%0d", c), out_rdata, st_rdata);
         chk($sformatf("hold_out_err_c%0d", c), 32'(out_err), 32'd0);
         chk($sformatf("hold_in_ready_c%0d", c), 32'(in_ready), 32'd0);
         if (c < 2) begin
            @(posedge clk); #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_in_ready_after", 32'(in_ready), 32'd1);
      chk("hold_out_valid_after", 32'(out_valid), 32'd0);

      // Timeout after four RESP cycles with no response
      req_rdy_en = 1'b1;
      resp_en    = 1'b0;
      in_valid   = 1'b1;
      in_addr    = 32'h80000020;
      in_op      = MEM_OP_W;
      in_ren     = 1'b1;
      in_wen     = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tmo_req_valid", 32'(mem_req_valid), 32'd1);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("tmo_wait_resp_ready_c%0d", c), 32'(mem_resp_ready), 32'd1);
         chk($sformatf("tmo_wait_out_valid_c%0d", c), 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      chk("tmo_out_valid", 32'(out_valid), 32'd1);
      chk("tmo_out_err", 32'(out_err), 32'd1);
      chk("tmo_out_rdata", out_rdata, 32'd0);
      chk("tmo_resp_ready_drop", 32'(mem_resp_ready), 32'd0);
      @(posedge clk); #1;
      chk("tmo_in_ready_back", 32'(in_ready), 32'd1);

      // Reset while waiting in RESP abandons the transaction
      in_valid = 1'b1;
      in_addr  = 32'h80000030;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_in_resp", 32'(mem_resp_ready), 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_in_ready", 32'(in_ready), 32'd1);
      chk("rstmid_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rstmid_resp_ready", 32'(mem_resp_ready), 32'd0);
      chk("rstmid_out_valid", 32'(out_valid), 32'd0);
      rst_n   = 1'b1;
      resp_en = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_stays_idle", 32'(out_valid), 32'd0);
      run_vec(vecs[7], 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
